// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage, its instruction memory and the decode stage.
interface if_stage_if;
  logic        id_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        int_exc;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        if_to_id_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_add4;
  logic [31:0] if_inst;
  logic        if_exc;
  logic [5:0]  if_excode;

  modport master (
    input  id_allowin, br_taken, br_target, int_exc,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output inst_req, inst_addr,
    output if_to_id_valid, if_pc, if_pc_add4, if_inst, if_exc, if_excode
  );

  modport slave (
    output id_allowin, br_taken, br_target, int_exc,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  inst_req, inst_addr,
    input  if_to_id_valid, if_pc, if_pc_add4, if_inst, if_exc, if_excode
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory request, branch redirect after the
// delay slot, exception flush with discard of in-flight data, AdEL on misaligned PC.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] EXC_PC   = 32'hbfc00380
) (
  input  logic         clk,
  input  logic         resetn,
  if_stage_if.master   bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned EW = 6;
  localparam logic [EW-1:0] EXC_ADEL = 6'h04;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] br_pc;
  logic [AW-1:0] if_pc_q;
  logic [AW-1:0] if_inst_q;
  logic          if_exc_q;
  logic          discard;
  logic          br_pending;
  logic          req;
  logic          valid;
  logic          aligned;
  logic          handshake;

  assign aligned   = (fetch_pc[1:0] == 2'b00);
  assign handshake = (state == S_VALID) && bus.id_allowin;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_REQ;
    else         state <= state_nxt;
  end

  // Next-state logic; int_exc overrides every other event
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        if (aligned) begin
          if (bus.inst_addr_ok) state_nxt = S_WAIT;
        end else if (!bus.int_exc) begin
          state_nxt = S_VALID;
        end
      end
      S_WAIT: begin
        if (bus.inst_data_ok)
          state_nxt = (bus.int_exc || discard) ? S_REQ : S_VALID;
      end
      S_VALID: begin
        if (bus.int_exc || handshake) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // Output decode; the request is held off while reset is asserted
  always_comb begin
    req   = 1'b0;
    valid = 1'b0;
    unique case (state)
      S_REQ:   req   = resetn && aligned;
      S_VALID: valid = 1'b1;
      default: ;
    endcase
  end

  // Fetch PC, redirect bookkeeping and the instruction register toward decode
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc   <= RESET_PC;
      br_pc      <= '0;
      br_pending <= 1'b0;
      discard    <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_inst_q  <= '0;
      if_exc_q   <= 1'b0;
    end else if (bus.int_exc) begin
      fetch_pc   <= EXC_PC;
      br_pending <= 1'b0;
      discard    <= ((state == S_WAIT) && !bus.inst_data_ok) || (req && bus.inst_addr_ok);
    end else begin
      if (handshake) begin
        br_pending <= 1'b0;
        if (bus.br_taken)  fetch_pc <= bus.br_target;
        else if (br_pending) fetch_pc <= br_pc;
        else                 fetch_pc <= fetch_pc + AW'(4);
      end else if (bus.br_taken) begin
        br_pending <= 1'b1;
        br_pc      <= bus.br_target;
      end

      if ((state == S_REQ) && !aligned) begin
        if_pc_q   <= fetch_pc;
        if_inst_q <= '0;
        if_exc_q  <= 1'b1;
      end

      if ((state == S_WAIT) && bus.inst_data_ok) begin
        if (discard) begin
          discard <= 1'b0;
        end else begin
          if_pc_q   <= fetch_pc;
          if_inst_q <= bus.inst_rdata;
          if_exc_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.inst_req       = req;
  assign bus.inst_addr      = fetch_pc;
  assign bus.if_to_id_valid = valid;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_pc_add4     = if_pc_q + AW'(4);
  assign bus.if_inst        = if_inst_q;
  assign bus.if_exc         = if_exc_q;
  assign bus.if_excode      = if_exc_q ? EXC_ADEL : '0;

endmodule

// File: tb/tb_if_stage.sv
// Random-stimulus bench for if_stage: a latency-randomised instruction memory plus a
// transaction-level model of which PC decode should see next.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam logic [31:0] EXC_PC   = 32'hbfc00380;
  localparam int NCYC    = 4000;
  localparam int RST_CYC = 2000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int delivered = 0;
  int exc_seen  = 0;
  int wraps     = 0;

  // Model: PC decode should see next, pending redirect, held flag, and the memory
  logic [31:0] exp_pc, pend_pc, mem_addr;
  bit          hold, pend, mem_busy, mem_stale;
  int          mem_cnt;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h24010001;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc    = RESET_PC;
    pend      = 1'b0;
    pend_pc   = '0;
    hold      = 1'b0;
    mem_busy  = 1'b0;
    mem_stale = 1'b0;
    mem_cnt   = 0;
    mem_addr  = '0;
  endtask

  task automatic drive_idle();
    bus.id_allowin   = 1'b0;
    bus.br_taken     = 1'b0;
    bus.br_target    = '0;
    bus.int_exc      = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
  endtask

  task automatic check_reset();
    check("rst_inst_req",  32'(bus.inst_req), 32'd0);
    check("rst_valid",     32'(bus.if_to_id_valid), 32'd0);
    check("rst_if_pc",     bus.if_pc, RESET_PC);
    check("rst_if_pc_add4", bus.if_pc_add4, RESET_PC + 32'd4);
    check("rst_if_inst",   bus.if_inst, 32'd0);
    check("rst_if_exc",    32'(bus.if_exc), 32'd0);
    check("rst_if_excode", 32'(bus.if_excode), 32'd0);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 7))
      0:       t = 32'hfffffffc;
      1: begin
        t = RESET_PC + 32'($urandom_range(0, 1023));
        if (t[1:0] == 2'b00) t = t + 32'd2;
      end
      2:       t = 32'hbfc00100;
      default: t = RESET_PC + 32'($urandom_range(0, 255) * 4);
    endcase
    return t;
  endfunction

  task automatic check_cycle();
    bit          exp_req, mis;
    exp_req = !hold && !mem_busy && (exp_pc[1:0] == 2'b00);
    mis     = (exp_pc[1:0] != 2'b00);
    check("valid",    32'(bus.if_to_id_valid), 32'(hold));
    check("inst_req", 32'(bus.inst_req), 32'(exp_req));
    if (exp_req) check("inst_addr", bus.inst_addr, exp_pc);
    if (hold) begin
      check("if_pc",      bus.if_pc, exp_pc);
      check("if_pc_add4", bus.if_pc_add4, exp_pc + 32'd4);
      check("if_inst",    bus.if_inst, mis ? 32'd0 : word_at(exp_pc));
      check("if_exc",     32'(bus.if_exc), 32'(mis));
      check("if_excode",  32'(bus.if_excode), mis ? 32'd4 : 32'd0);
    end
  endtask

  task automatic drive_random();
    bus.inst_addr_ok = bus.inst_req && ($urandom_range(0, 1) == 1);
    bus.inst_data_ok = mem_busy && (mem_cnt == 0);
    bus.inst_rdata   = bus.inst_data_ok ? word_at(mem_addr) : 32'($urandom);
    bus.id_allowin   = ($urandom_range(0, 9) < 7);
    bus.br_taken     = ($urandom_range(0, 9) == 0);
    bus.br_target    = bus.br_taken ? pick_target() : 32'($urandom);
    bus.int_exc      = ($urandom_range(0, 63) == 0);
  endtask

  // Advance the model across the coming rising edge using the inputs just driven
  task automatic model_step();
    bit hold0, busy0, got_data, hs;
    hold0    = hold;
    busy0    = mem_busy;
    got_data = bus.inst_data_ok && !mem_stale;
    hs       = hold0 && bus.id_allowin;

    if (bus.inst_data_ok) begin
      mem_busy  = 1'b0;
      mem_stale = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
    end

    if (bus.int_exc) begin
      if (mem_busy) mem_stale = 1'b1;
      if (bus.inst_addr_ok) begin
        mem_busy  = 1'b1;
        mem_stale = 1'b1;
        mem_addr  = bus.inst_addr;
        mem_cnt   = $urandom_range(0, 2);
      end
      exp_pc = EXC_PC;
      pend   = 1'b0;
      hold   = 1'b0;
    end else begin
      if (got_data) begin
        hold = 1'b1;
        delivered++;
      end
      if (bus.inst_addr_ok) begin
        mem_busy  = 1'b1;
        mem_stale = 1'b0;
        mem_addr  = bus.inst_addr;
        mem_cnt   = $urandom_range(0, 2);
      end
      if (!hold0 && !busy0 && (exp_pc[1:0] != 2'b00)) begin
        hold = 1'b1;
        exc_seen++;
      end
      if (hs) begin
        if (exp_pc == 32'hfffffffc && !bus.br_taken && !pend) wraps++;
        if (bus.br_taken) exp_pc = bus.br_target;
        else if (pend)    exp_pc = pend_pc;
        else              exp_pc = exp_pc + 32'd4;
        pend = 1'b0;
        hold = 1'b0;
      end else if (bus.br_taken) begin
        pend    = 1'b1;
        pend_pc = bus.br_target;
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_reset();
    resetn = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc == RST_CYC) begin
        resetn = 1'b0;
        drive_idle();
        model_reset();
        #1;
        check_reset();
        @(negedge clk);
        resetn = 1'b1;
        continue;
      end
      check_cycle();
      drive_random();
      model_step();
    end

    check("progress", 32'(delivered > 50), 32'd1);
    check("adel_seen", 32'(exc_seen > 0), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hbfc00000, the first fetch address after reset.
REQ-002 SHALL have parameter EXC_PC, default 32'hbfc00380, the fetch address after int_exc.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 resetn  in  1  asynchronous active-low reset.
REQ-006 id_allowin  in  1  decode stage can accept an instruction this cycle.
REQ-007 br_taken  in  1  decode resolved a taken jump/branch/eret (combinational from decode).
REQ-008 br_target  in  32  redirect PC, valid when br_taken=1.
REQ-009 int_exc  in  1  exception/interrupt flush; one-cycle pulse.
REQ-010 inst_req  out  1  instruction-memory request valid.
REQ-011 inst_addr  out  32  request address (= fetch_pc).
REQ-012 inst_addr_ok  in  1  memory accepted the request this cycle.
REQ-013 inst_data_ok  in  1  inst_rdata valid this cycle; never in the same cycle as its own addr_ok.
REQ-014 inst_rdata  in  32  fetched instruction word.
REQ-015 if_to_id_valid  out  1  instruction held for decode.
REQ-016 if_pc  out  32  PC of the held instruction.
REQ-017 if_pc_add4  out  32  if_pc + 4, wrapping modulo 2^32.
REQ-018 if_inst  out  32  held instruction.
REQ-019 if_exc  out  1  held instruction carries a fetch exception.
REQ-020 if_excode  out  6  exception code; 6'h04 (AdEL) when if_exc=1, else 0.

Function
REQ-021 SHALL implement FSM states S_REQ, S_WAIT, S_VALID, with at most one outstanding memory request.
REQ-022 S_REQ, aligned fetch_pc: inst_req=1; on inst_addr_ok, go to S_WAIT.
REQ-023 S_REQ, fetch_pc[1:0]!=0: inst_req=0; capture if_pc=fetch_pc, if_inst=0, if_exc=1, if_excode=6'h04; go to S_VALID next cycle.
REQ-024 S_WAIT: on inst_data_ok, with discard=0, latch if_inst=inst_rdata, if_pc=fetch_pc, if_exc=0, and go to S_VALID.
REQ-025 S_WAIT: on inst_data_ok, with discard=1, drop the data, clear discard, and go to S_REQ.
REQ-026 S_VALID: if_to_id_valid=1; outputs hold stable until handshake (if_to_id_valid & id_allowin).
REQ-027 On handshake, fetch_pc SHALL become br_target if br_taken=1 that cycle, else br_pc if br_pending=1, else fetch_pc+4; FSM goes to S_REQ.
REQ-028 br_taken=1 without handshake SHALL set br_pending=1 and br_pc=br_target, with a later br_taken overwriting; a handshake clears br_pending.
REQ-029 The instruction in IF when br_taken asserts (delay slot) SHALL still be delivered; the redirect applies to the following fetch.
REQ-030 int_exc SHALL take priority over all other events in its cycle.
REQ-031 int_exc effects: fetch_pc=EXC_PC, br_pending=0, if_to_id_valid=0 next cycle, FSM to S_REQ.
REQ-032 int_exc in S_WAIT without data_ok, or in S_REQ with inst_addr_ok, SHALL set discard=1 and go to (or stay in) S_WAIT.
REQ-033 int_exc in S_WAIT with inst_data_ok SHALL drop the data and go to S_REQ.
REQ-034 if_to_id_valid SHALL be 0 in S_REQ and S_WAIT.
REQ-035 inst_req SHALL deassert in the cycle after inst_addr_ok.

Reset
REQ-036 resetn=0 SHALL asynchronously force: FSM=S_REQ, fetch_pc=RESET_PC, if_pc=RESET_PC, if_pc_add4=RESET_PC+4, if_inst=0, if_exc=0, if_excode=0, discard=0, br_pending=0, br_pc=0.
REQ-037 While resetn=0, inst_req=0 and if_to_id_valid=0.
REQ-038 In the first cycle after reset release, inst_req=1 and inst_addr=32'hbfc00000.
REQ-039 Reset asserted mid-request SHALL abandon the request with no discard tracking; memory is reset alongside.

Verification
REQ-040 Sequential fetch: reset release; addr_ok next cycle; data_ok one cycle later with 32'h24010001; id_allowin=1 -> if_pc=bfc00000, if_inst=24010001, valid one cycle, next inst_addr=bfc00004.
REQ-041 Stall: id_allowin=0 for 3 cycles in S_VALID -> outputs stable, inst_req=0, no fetch_pc advance.
REQ-042 Branch: br_taken=1, br_target=bfc00100 while delay slot bfc00008 is in S_WAIT -> delay slot delivered, then inst_addr=bfc00100.
REQ-043 Flush mid-flight: int_exc in S_WAIT, data_ok two cycles later -> data dropped, if_to_id_valid stays 0, next inst_addr=bfc00380.
REQ-044 Misaligned: br_target=bfc00102 -> no inst_req; if_exc=1, if_excode=04, if_inst=0, if_pc=bfc00102, valid=1.
REQ-045 Wrap: fetch_pc=32'hfffffffc -> if_pc_add4=0, and the next sequential inst_addr=0.
